// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse master controller.
package mouse_pkg;

  // One-hot controller states.
  typedef enum logic [12:0] {
    ST_INIT          = 13'h0001,
    ST_SEND_FF       = 13'h0002,
    ST_WAIT_TX_FF    = 13'h0004,
    ST_WAIT_ACK_FF   = 13'h0008,
    ST_WAIT_SELFTEST = 13'h0010,
    ST_WAIT_ID       = 13'h0020,
    ST_SEND_F4       = 13'h0040,
    ST_WAIT_TX_F4    = 13'h0080,
    ST_WAIT_ACK_F4   = 13'h0100,
    ST_STREAM_B1     = 13'h0200,
    ST_STREAM_B2     = 13'h0400,
    ST_STREAM_B3     = 13'h0800,
    ST_PUBLISH       = 13'h1000
  } state_e;

  // Receiver error codes reported alongside each byte.
  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_PARITY = 2'd1,
    ERR_STOP   = 2'd2
  } byte_err_e;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_SELFTEST = 8'hAA;
  localparam logic [7:0] RSP_ID       = 8'h00;

  // States in which the receiver is enabled and incoming bytes are consumed.
  function automatic logic is_rx_state(state_e s);
    return (s == ST_WAIT_ACK_FF) || (s == ST_WAIT_SELFTEST) || (s == ST_WAIT_ID) ||
           (s == ST_WAIT_ACK_F4) || (s == ST_STREAM_B1) || (s == ST_STREAM_B2) ||
           (s == ST_STREAM_B3);
  endfunction

  // Init-phase states guarded by the response timeout.
  function automatic logic is_timed_state(state_e s);
    return (s == ST_WAIT_TX_FF) || (s == ST_WAIT_ACK_FF) || (s == ST_WAIT_SELFTEST) ||
           (s == ST_WAIT_ID) || (s == ST_WAIT_TX_F4) || (s == ST_WAIT_ACK_F4);
  endfunction

endpackage

// File: rtl/mouse_master_sm_if.sv
// Handshake bundle between the mouse master controller, the PS/2
// transmitter/receiver and the bus-side mouse registers.
interface mouse_master_sm_if;
  logic       send_byte;
  logic [7:0] byte_to_send;
  logic       byte_sent;
  logic       read_enable;
  logic       byte_read;
  logic [1:0] byte_error_code;
  logic [7:0] byte_received;
  logic [7:0] mouse_status;
  logic [7:0] mouse_dx;
  logic [7:0] mouse_dy;
  logic       send_interrupt;

  modport master (
    output send_byte, byte_to_send, read_enable,
           mouse_status, mouse_dx, mouse_dy, send_interrupt,
    input  byte_sent, byte_read, byte_error_code, byte_received
  );

  modport slave (
    input  send_byte, byte_to_send, read_enable,
           mouse_status, mouse_dx, mouse_dy, send_interrupt,
    output byte_sent, byte_read, byte_error_code, byte_received
  );
endinterface

// File: rtl/mouse_master_sm.sv
// PS/2 mouse master: runs the reset/self-test/stream-enable handshake, then
// assembles 3-byte movement packets and publishes them with an interrupt.
module mouse_master_sm
  import mouse_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 500_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  mouse_master_sm_if.master bus
);

  localparam int PWR_W = $clog2(POWERUP_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(POWERUP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             send_byte_q, read_enable_q, send_interrupt_q;
  logic [7:0]       byte_to_send_q;
  logic [7:0]       status_sh_q, dx_sh_q, dy_sh_q;
  logic [7:0]       status_q, dx_q, dy_q;
  logic             rx_err, tmo_hit;

  // Next state and counter values; a received byte always wins over a timeout.
  always_comb begin
    state_d = state_q;
    rx_err  = bus.byte_read && (bus.byte_error_code != ERR_NONE);
    tmo_hit = (tmo_cnt_q == TMO_LAST);
    case (state_q)
      ST_INIT:          if (pwr_cnt_q == PWR_LAST) state_d = ST_SEND_FF;
      ST_SEND_FF:       state_d = ST_WAIT_TX_FF;
      ST_WAIT_TX_FF:    if (bus.byte_sent) state_d = ST_WAIT_ACK_FF;
                        else if (tmo_hit) state_d = ST_INIT;
      ST_WAIT_ACK_FF:   if (bus.byte_read)
                          state_d = (rx_err || bus.byte_received != RSP_ACK) ? ST_INIT : ST_WAIT_SELFTEST;
                        else if (tmo_hit) state_d = ST_INIT;
      ST_WAIT_SELFTEST: if (bus.byte_read)
                          state_d = (rx_err || bus.byte_received != RSP_SELFTEST) ? ST_INIT : ST_WAIT_ID;
                        else if (tmo_hit) state_d = ST_INIT;
      ST_WAIT_ID:       if (bus.byte_read)
                          state_d = (rx_err || bus.byte_received != RSP_ID) ? ST_INIT : ST_SEND_F4;
                        else if (tmo_hit) state_d = ST_INIT;
      ST_SEND_F4:       state_d = ST_WAIT_TX_F4;
      ST_WAIT_TX_F4:    if (bus.byte_sent) state_d = ST_WAIT_ACK_F4;
                        else if (tmo_hit) state_d = ST_INIT;
      ST_WAIT_ACK_F4:   if (bus.byte_read)
                          state_d = (rx_err || bus.byte_received != RSP_ACK) ? ST_INIT : ST_STREAM_B1;
                        else if (tmo_hit) state_d = ST_INIT;
      // Only a clean byte with the always-one bit 3 set can start a packet.
      ST_STREAM_B1:     if (bus.byte_read && !rx_err && bus.byte_received[3]) state_d = ST_STREAM_B2;
      ST_STREAM_B2:     if (bus.byte_read) state_d = rx_err ? ST_STREAM_B1 : ST_STREAM_B3;
      ST_STREAM_B3:     if (bus.byte_read) state_d = rx_err ? ST_STREAM_B1 : ST_PUBLISH;
      ST_PUBLISH:       state_d = ST_STREAM_B1;
      default:          state_d = ST_INIT;
    endcase

    pwr_cnt_d = (state_q == ST_INIT && state_d == ST_INIT) ? pwr_cnt_q + 1'b1 : '0;
    tmo_cnt_d = (state_q == state_d && is_timed_state(state_q)) ? tmo_cnt_q + 1'b1 : '0;
  end

  // State, counters, shadow packet registers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q          <= ST_INIT;
      pwr_cnt_q        <= '0;
      tmo_cnt_q        <= '0;
      send_byte_q      <= 1'b0;
      byte_to_send_q   <= 8'h00;
      read_enable_q    <= 1'b0;
      send_interrupt_q <= 1'b0;
      status_sh_q      <= 8'h00;
      dx_sh_q          <= 8'h00;
      dy_sh_q          <= 8'h00;
      status_q         <= 8'h00;
      dx_q             <= 8'h00;
      dy_q             <= 8'h00;
    end else begin
      state_q       <= state_d;
      pwr_cnt_q     <= pwr_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      send_byte_q   <= (state_d == ST_SEND_FF) || (state_d == ST_SEND_F4);
      read_enable_q <= is_rx_state(state_d);
      if (state_d == ST_SEND_FF) byte_to_send_q <= CMD_RESET;
      else if (state_d == ST_SEND_F4) byte_to_send_q <= CMD_ENABLE;
      if (state_q == ST_STREAM_B1 && state_d == ST_STREAM_B2) status_sh_q <= bus.byte_received;
      if (state_q == ST_STREAM_B2 && state_d == ST_STREAM_B3) dx_sh_q <= bus.byte_received;
      if (state_q == ST_STREAM_B3 && state_d == ST_PUBLISH) dy_sh_q <= bus.byte_received;
      send_interrupt_q <= (state_q == ST_PUBLISH);
      if (state_q == ST_PUBLISH) begin
        status_q <= status_sh_q;
        dx_q     <= dx_sh_q;
        dy_q     <= dy_sh_q;
      end
    end
  end

  assign bus.send_byte      = send_byte_q;
  assign bus.byte_to_send   = byte_to_send_q;
  assign bus.read_enable    = read_enable_q;
  assign bus.mouse_status   = status_q;
  assign bus.mouse_dx       = dx_q;
  assign bus.mouse_dy       = dy_q;
  assign bus.send_interrupt = send_interrupt_q;

endmodule
